// File: rtl/seq_pkg.sv
// Shared types for the Fibonacci stream buffer: sample type, FIFO entry, checker states.
package seq_pkg;

    typedef logic [31:0] seq_t;

    typedef struct packed {
        seq_t       data;
        logic       wrap;
        logic [7:0] idx;
    } seq_entry_t;

    typedef enum logic [1:0] {
        PRIME0,
        PRIME1,
        CHECK
    } chk_state_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO of seq_entry_t. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits are equal.
module seq_fifo
    import seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  seq_entry_t wdata,
    input  logic       pop,
    output seq_entry_t rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    seq_entry_t    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // Storage array; no reset needed, validity is tracked by the pointers.
    // A push while full-and-popping reuses the slot being read out this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers; a push is only issued by the owner when space exists
    // or a pop frees one in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop && !empty) rptr <= rptr + PW'(1);
        end
    end

endmodule

// File: rtl/fib_stream_buffer.sv
// Consumer of the sequence generator stream: checks the Fibonacci recurrence
// mod 2^32, tags each sample with a wrap flag and index, buffers it, and hands
// it downstream over valid/ready, counting samples lost to a full FIFO.
module fib_stream_buffer
    import seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       seq_i,
    input  logic              seq_vld_i,
    output logic [31:0]       out_data_o,
    output logic              out_wrap_o,
    output logic [7:0]        out_idx_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              err_o,
    output logic              full_o,
    output logic [DROP_W-1:0] drop_cnt_o
);
    chk_state_t        state;
    chk_state_t        state_nxt;
    seq_t              p1;
    seq_t              p2;
    seq_t              prev;
    seq_t              sum;
    logic [7:0]        idx;
    logic [DROP_W-1:0] drop_cnt;
    logic              err;
    logic              wrap;
    logic              mismatch;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    seq_entry_t        wentry;
    seq_entry_t        head;

    assign sum      = p1 + p2;
    assign mismatch = seq_vld_i && (state == CHECK) && (seq_i != sum);
    // Any state past PRIME0 means at least one sample has been seen since reset.
    assign wrap     = (state != PRIME0) && (seq_i < prev);

    assign pop    = !empty && out_ready_i;
    assign push   = seq_vld_i && (!full || pop);
    assign wentry = '{data: seq_i, wrap: wrap, idx: idx};

    seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Head fields are forced to zero while empty so reset values are defined.
    assign out_valid_o = !empty;
    assign out_data_o  = empty ? '0 : head.data;
    assign out_wrap_o  = empty ? 1'b0 : head.wrap;
    assign out_idx_o   = empty ? '0 : head.idx;
    assign err_o       = err;
    assign full_o      = full;
    assign drop_cnt_o  = drop_cnt;

    // Checker state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PRIME0;
        else       state <= state_nxt;
    end

    // Checker next state: advances only on valid samples.
    always_comb begin
        state_nxt = state;
        if (seq_vld_i) begin
            case (state)
                PRIME0:  state_nxt = PRIME1;
                PRIME1:  state_nxt = CHECK;
                CHECK:   state_nxt = CHECK;
                default: state_nxt = PRIME0;
            endcase
        end
    end

    // Recurrence history, previous sample, index, sticky error and drop count.
    // Every valid sample feeds these, including dropped ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1       <= '0;
            p2       <= '0;
            prev     <= '0;
            idx      <= '0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (seq_vld_i) begin
            case (state)
                PRIME0:  p2 <= seq_i;
                PRIME1:  p1 <= seq_i;
                default: begin
                    p2 <= p1;
                    p1 <= seq_i;
                end
            endcase
            prev <= seq_i;
            idx  <= idx + 8'd1;
            if (mismatch) err <= 1'b1;
            if (!push && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_fib_stream_buffer.sv
// Self-checking bench for fib_stream_buffer: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_fib_stream_buffer;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       seq_i = '0;
    logic              seq_vld_i = 1'b0;
    logic [31:0]       out_data_o;
    logic              out_wrap_o;
    logic [7:0]        out_idx_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic              err_o;
    logic              full_o;
    logic [DROP_W-1:0] drop_cnt_o;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] q_data [$];
    logic        q_wrap [$];
    logic [7:0]  q_idx  [$];
    int          m_cnt;
    logic [31:0] m_p1, m_p2;
    logic        m_err;
    int          m_drop;
    int          m_idx;

    fib_stream_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .seq_i       (seq_i),
        .seq_vld_i   (seq_vld_i),
        .out_data_o  (out_data_o),
        .out_wrap_o  (out_wrap_o),
        .out_idx_o   (out_idx_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o),
        .full_o      (full_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_data.delete();
        q_wrap.delete();
        q_idx.delete();
        m_cnt = 0;
        m_p1 = '0;
        m_p2 = '0;
        m_err = 1'b0;
        m_drop = 0;
        m_idx = 0;
    endtask

    task automatic check_all();
        chk("valid", 32'(out_valid_o), 32'(q_data.size() > 0));
        if (q_data.size() > 0) begin
            chk("data", out_data_o, q_data[0]);
            chk("wrap", 32'(out_wrap_o), 32'(q_wrap[0]));
            chk("idx", 32'(out_idx_o), 32'(q_idx[0]));
        end
        chk("err", 32'(err_o), 32'(m_err));
        chk("full", 32'(full_o), 32'(q_data.size() == DEPTH));
        chk("drop", 32'(drop_cnt_o), 32'(m_drop));
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_wrap", 32'(out_wrap_o), 0);
        chk("rst_idx", 32'(out_idx_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_drop", 32'(drop_cnt_o), 0);
    endtask

    // one clock cycle with given inputs; model advances at the edge, outputs checked #1 after
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        bit          do_pop, do_push, is_full;
        logic        w;
        logic [31:0] s;
        seq_vld_i   = v;
        seq_i       = d;
        out_ready_i = r;
        @(posedge clk);
        do_pop  = r && (q_data.size() > 0);
        is_full = (q_data.size() == DEPTH);
        do_push = v && (!is_full || do_pop);
        if (do_pop) begin
            void'(q_data.pop_front());
            void'(q_wrap.pop_front());
            void'(q_idx.pop_front());
        end
        if (v) begin
            s = m_p1 + m_p2;
            if (m_cnt >= 2 && d != s) m_err = 1'b1;
            w = (m_cnt > 0) && (d < m_p1);
            if (do_push) begin
                q_data.push_back(d);
                q_wrap.push_back(w);
                q_idx.push_back(8'(m_idx));
            end else if (m_drop < (1 << DROP_W) - 1) begin
                m_drop++;
            end
            m_p2 = m_p1;
            m_p1 = d;
            m_cnt++;
            m_idx = (m_idx + 1) % 256;
        end
        #1;
        check_all();
    endtask

    task automatic feed_fib(input int n, input logic r);
        logic [31:0] nx;
        for (int i = 0; i < n; i++) begin
            if (m_cnt == 0)      nx = 32'd0;
            else if (m_cnt == 1) nx = 32'd1;
            else                 nx = m_p1 + m_p2;
            step(1'b1, nx, r);
        end
    endtask

    // asynchronous reset taken between edges; outputs must clear without a clock
    task automatic do_reset();
        seq_vld_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals();
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int d0;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // normal flow
        step(1, 0, 1); step(1, 1, 1); step(1, 1, 1); step(1, 2, 1);
        step(1, 3, 1); step(1, 5, 1); step(1, 8, 1);
        step(0, 0, 1);

        // arithmetic wrap
        do_reset();
        step(1, 32'd1836311903, 0);
        step(1, 32'd2971215073, 0);
        step(1, 32'd512559680, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("wrap3", 32'(out_wrap_o), 1);
        step(0, 0, 1);
        chk("wrap_err", 32'(err_o), 0);

        // recurrence error stays sticky
        do_reset();
        step(1, 0, 1); step(1, 1, 1); step(1, 1, 1); step(1, 2, 1); step(1, 4, 1);
        chk("err_set", 32'(err_o), 1);
        step(1, 6, 1); step(1, 10, 1);
        chk("err_sticky", 32'(err_o), 1);

        // overflow then drain
        do_reset();
        feed_fib(10, 0);
        chk("ovf_full", 32'(full_o), 1);
        chk("ovf_drop", 32'(drop_cnt_o), 2);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_idx", 32'(out_idx_o), i);
            step(0, 0, 1);
        end
        feed_fib(1, 1);
        chk("post_drop_err", 32'(err_o), 0);

        // full with simultaneous push and pop
        step(0, 0, 1);
        feed_fib(DEPTH, 0);
        chk("pp_full", 32'(full_o), 1);
        d0 = int'(drop_cnt_o);
        feed_fib(1, 1);
        chk("pp_drop", 32'(drop_cnt_o), 32'(d0));
        chk("pp_full2", 32'(full_o), 1);

        // reset mid-stream with data buffered and error set
        do_reset();
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0); step(1, 2, 0); step(1, 4, 0);
        chk("mid_err", 32'(err_o), 1);
        do_reset();
        step(1, 0, 1); step(1, 1, 1); step(1, 1, 1);
        chk("mid_after", 32'(err_o), 0);

        // random traffic with occasional corruption and resets
        for (int c = 0; c < 600; c++) begin
            logic        v, r;
            logic [31:0] nx;
            if (c % 200 == 199) do_reset();
            v = ($urandom % 4) != 0;
            r = ($urandom % 3) != 0;
            if (m_cnt == 0)                nx = 32'd0;
            else if (m_cnt == 1)           nx = 32'd1;
            else if ($urandom % 40 == 0)   nx = $urandom;
            else                           nx = m_p1 + m_p2;
            step(v, nx, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fib_stream_buffer.md
# fib_stream_buffer

Downstream consumer of the 32-bit sequence generator. Samples the generator's `seq_o` stream on each qualified cycle and checks every sample against the Fibonacci recurrence (mod 2^32). Flags arithmetic wrap-around and buffers samples in a small FIFO. Delivers the samples to the next stage over a valid/ready handshake, and counts samples it has to drop.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `DROP_W`, 16: drop-counter width; the counter saturates.
- `clk` in 1: clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `seq_i` in 32: sample from the sequence generator.
- `seq_vld_i` in 1: `seq_i` is valid this cycle. There is no backpressure upstream.
- `out_data_o` out 32: sample at the FIFO head.
- `out_wrap_o` out 1: the head sample is smaller than its predecessor (wrap occurred).
- `out_idx_o` out 8: accepted-sample index of the head, mod 256.
- `out_valid_o` out 1: the head is valid.
- `out_ready_i` in 1: the downstream stage accepts the head.
- `err_o` out 1: sticky flag; the recurrence was violated.
- `full_o` out 1: FIFO full.
- `drop_cnt_o` out `DROP_W`: number of samples dropped because the FIFO was full.

## Operation
- Checker FSM, evaluated only on cycles with `seq_vld_i=1`:
  - PRIME0: latch p2=`seq_i`, go to PRIME1.
  - PRIME1: latch p1=`seq_i`, go to CHECK.
  - CHECK: if `seq_i` ≠ (p1+p2)[31:0], set `err_o`. Then shift: p2←p1, p1←`seq_i`. Stay in CHECK.
- The checker sees every valid input, including dropped ones. Drops do not desynchronise the check.
- Wrap bit:
  - Set when `seq_i` < the previous valid sample.
  - Always 0 for the first sample after reset.
- Sample index: an 8-bit counter that increments on every valid input, dropped or not, and wraps 255→0. The first sample after reset has index 0.
- FIFO push: a valid input writes {`seq_i`, wrap, idx} to the FIFO unless the FIFO is full and not popping this cycle.
  - Full and popping in the same cycle: the push is accepted and no drop occurs.
- Drop: a valid input that is not pushed increments `drop_cnt_o`. The counter saturates at 2^`DROP_W`−1.
- Pop: occurs when `out_valid_o` & `out_ready_i`. The head advances on that clock edge.
- Pointers: `log2(DEPTH)`+1 bits each. Full and empty are derived from the pointer MSBs.
- `err_o` is cleared only by `reset`.

## Timing
- Reset values:
  - `out_valid_o`=0, `out_data_o`=0, `out_wrap_o`=0, `out_idx_o`=0.
  - `err_o`=0, `full_o`=0, `drop_cnt_o`=0.
  - FSM in PRIME0, index counter 0, FIFO empty.
- Latency:
  - A sample pushed at edge N is presented with `out_valid_o`=1 after edge N. There is no combinational path from `seq_i` to the outputs.
  - `err_o` rises after the edge that samples the offending value.
- `out_data_o`, `out_wrap_o` and `out_idx_o` hold stable while `out_valid_o`=1 and `out_ready_i`=0.
- Empty FIFO: `out_valid_o`=0 and `out_ready_i` is ignored. The output data fields are don't-care.
- `full_o` is registered state. It deasserts after the edge of the first pop that is not paired with a push.
- Reset mid-operation:
  - Discards all FIFO contents, FSM state and counters immediately (asynchronously).
  - The first valid sample after reset release re-enters PRIME0.

## Structure
- Package `seq_pkg` holds:
  - `seq_t` (logic [31:0]);
  - the FIFO entry struct `seq_entry_t` {`seq_t` data; logic wrap; logic [7:0] idx};
  - the checker state enum {PRIME0, PRIME1, CHECK}.
- One sub-module, `seq_fifo`: a parameterised synchronous FIFO with push, pop, full and empty, storing `seq_entry_t`.
- The checker, wrap detection, index counter and drop counter live in the top module.

## Test plan
- Normal flow: feed 0,1,1,2,3,5,8 on consecutive cycles with `out_ready_i`=1.
  - Same values appear one cycle later with idx 0..6.
  - `out_wrap_o`=0 and `err_o`=0 throughout.
- Wrap: feed consecutive Fibonacci terms 1836311903, 2971215073, 512559680.
  - The third entry has `out_wrap_o`=1.
  - `err_o` stays 0, because the sum is checked mod 2^32.
- Recurrence error: feed 0,1,1,2,4.
  - `err_o`=1 after the edge sampling 4.
  - Feed 6,10 afterwards: `err_o` remains 1.
- Overflow: hold `out_ready_i`=0 and push 10 Fibonacci samples with `DEPTH`=8.
  - `full_o`=1 and `drop_cnt_o`=2.
  - Draining yields idx 0..7.
  - A subsequent recurrence check still passes.
- Full with simultaneous push and pop: FIFO full, `out_ready_i`=1, and one valid input in the same cycle.
  - The pop succeeds, the push is stored and `drop_cnt_o` is unchanged.
- Reset mid-stream: assert `reset` with 5 entries buffered and `err_o`=1.
  - All outputs return to their reset values in the same cycle.
  - After release, 0,1,1 passes without error.
